// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder: adds WIDTH-bit operands plus carry-in DIGIT bits per clock,
// chaining a registered carry between chunks, with a start/busy/done handshake.
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("chunk_serial_adder: DIGIT must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, res, res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] a_chunk, b_chunk;
  logic [DIGIT:0]   chunk_sum;
  logic             msb_carry_in;
  int               base;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // One chunk of the ripple: the DIGIT+1 bit sum carries its top bit into the next cycle.
  always_comb begin
    base         = DIGIT * int'(cnt);
    a_chunk      = op_a[base +: DIGIT];
    b_chunk      = op_b[base +: DIGIT];
    chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{DIGIT{1'b0}}, carry};
    res_next     = res;
    res_next[base +: DIGIT] = chunk_sum[DIGIT-1:0];
    msb_carry_in = a_chunk[DIGIT-1] ^ b_chunk[DIGIT-1] ^ chunk_sum[DIGIT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          op_a  <= a;
          op_b  <= b;
          carry <= cin;
          cnt   <= '0;
          res   <= '0;
        end
      end else begin
        res   <= res_next;
        carry <= chunk_sum[DIGIT];
        // Visible results only change here, so they hold through the whole next run.
        if (cnt == LAST) begin
          sum      <= res_next;
          cout     <= chunk_sum[DIGIT];
          overflow <= msb_carry_in ^ chunk_sum[DIGIT];
          done     <= 1'b1;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Self-checking bench for chunk_serial_adder: a 4-chunk instance and a single-chunk
// instance, checked against an arithmetic reference model.
module tb_chunk_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic [15:0] sum0, sum1;
  logic        cout0, cout1, ov0, ov1, busy0, busy1, done0, done1;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] last0 = '0, last1 = '0;

  always #5 clk = ~clk;

  chunk_serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start0), .a(a), .b(b), .cin(cin),
    .sum(sum0), .cout(cout0), .overflow(ov0), .busy(busy0), .done(done0)
  );

  chunk_serial_adder #(.WIDTH(16), .DIGIT(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin),
    .sum(sum1), .cout(cout1), .overflow(ov1), .busy(busy1), .done(done1)
  );

  // Reference: unsigned sum for result/carry, signed integer range test for overflow.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                                output logic [15:0] s, output logic co, output logic ov);
    logic [16:0] t;
    int sa, sb, total;
    t  = {1'b0, ma} + {1'b0, mb} + 17'(mc);
    s  = t[15:0];
    co = t[16];
    sa = $signed(ma);
    sb = $signed(mb);
    total = sa + sb + int'(mc);
    ov = (total > 32767) || (total < -32768);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input bit wide);
    a = ia;
    b = ib;
    cin = ic;
    if (wide) start1 = 1'b1;
    else      start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit wide, output int cycles, output bit timed_out);
    timed_out = 1'b1;
    cycles = -1;
    for (int i = 0; i <= 50; i++) begin
      if ((wide ? done1 : done0) === 1'b1) begin
        cycles = i;
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (sum0 !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_sum0 got %h want 0000", sum0); end
    vectors++; if (cout0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cout0 got %b want 0", cout0); end
    vectors++; if (ov0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ov0 got %b want 0", ov0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy0 got %b want 0", busy0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done0 got %b want 0", done0); end
    vectors++; if (sum1 !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_sum1 got %h want 0000", sum1); end
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy1 got %b want 0", busy1); end
    rst = 1'b0;
    tick();
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_hold_busy got %b want 0", busy0); end
    last0 = '0;
    last1 = '0;
  endtask

  task automatic test_directed;
    logic [15:0] va [4] = '{16'h7FFF, 16'hFFFF, 16'h1234, 16'h8000};
    logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h4321, 16'h8000};
    logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] es;
    logic        ec, eo;
    int          cyc;
    bit          to;
    for (int i = 0; i < 4; i++) begin
      model(va[i], vb[i], vc[i], es, ec, eo);
      start_op(va[i], vb[i], vc[i], 1'b0);
      vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("[TB] FAIL dir_busy[%0d] got %b want 1", i, busy0); end
      vectors++; if (sum0 !== last0) begin miscompares++; $display("[TB] FAIL dir_sum_hold[%0d] got %h want %h", i, sum0, last0); end
      wait_done(1'b0, cyc, to);
      vectors++; if (to || cyc != 4) begin miscompares++; $display("[TB] FAIL dir_latency[%0d] got %0d want 4 (timeout=%0b)", i, cyc, to); end
      vectors++; if (sum0 !== es) begin miscompares++; $display("[TB] FAIL dir_sum[%0d] got %h want %h", i, sum0, es); end
      vectors++; if (cout0 !== ec) begin miscompares++; $display("[TB] FAIL dir_cout[%0d] got %b want %b", i, cout0, ec); end
      vectors++; if (ov0 !== eo) begin miscompares++; $display("[TB] FAIL dir_ov[%0d] got %b want %b", i, ov0, eo); end
      last0 = es;
      tick();
      vectors++; if (done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL dir_done_pulse[%0d] got %b want 0", i, done0); end
    end
  endtask

  task automatic test_busy_reject;
    logic [15:0] xa, xb, es;
    logic        xc, ec, eo;
    int          cyc;
    bit          to;
    xa = 16'($urandom);
    xb = 16'($urandom);
    xc = 1'($urandom);
    model(xa, xb, xc, es, ec, eo);
    start_op(xa, xb, xc, 1'b0);
    // Hammer start and scramble operands through the run.
    for (int i = 0; i < 3; i++) begin
      start0 = 1'b1;
      a = (i == 0) ? 16'h0001 : 16'($urandom);
      b = (i == 0) ? 16'h0001 : 16'($urandom);
      cin = 1'($urandom);
      vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("[TB] FAIL rej_busy[%0d] got %b want 1", i, busy0); end
      vectors++; if (sum0 !== last0) begin miscompares++; $display("[TB] FAIL rej_sum_hold[%0d] got %h want %h", i, sum0, last0); end
      tick();
    end
    start0 = 1'b0;
    wait_done(1'b0, cyc, to);
    vectors++; if (to || cyc != 1) begin miscompares++; $display("[TB] FAIL rej_latency got %0d want 1 (timeout=%0b)", cyc, to); end
    vectors++; if (sum0 !== es) begin miscompares++; $display("[TB] FAIL rej_sum got %h want %h", sum0, es); end
    vectors++; if ({cout0, ov0} !== {ec, eo}) begin miscompares++; $display("[TB] FAIL rej_flags got %b%b want %b%b", cout0, ov0, ec, eo); end
    last0 = es;
    tick();
    vectors++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rej_no_restart got busy=%b done=%b want 0 0", busy0, done0); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] xa, xb, ya, yb, es1, es2;
    logic        xc, yc, ec1, eo1, ec2, eo2;
    int          cyc;
    bit          to;
    xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom);
    ya = 16'($urandom); yb = 16'($urandom); yc = 1'($urandom);
    model(xa, xb, xc, es1, ec1, eo1);
    model(ya, yb, yc, es2, ec2, eo2);
    start_op(xa, xb, xc, 1'b0);
    wait_done(1'b0, cyc, to);
    vectors++; if (to || sum0 !== es1) begin miscompares++; $display("[TB] FAIL b2b_first_sum got %h want %h (timeout=%0b)", sum0, es1, to); end
    start_op(ya, yb, yc, 1'b0);
    vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_accept got busy=%b want 1", busy0); end
    wait_done(1'b0, cyc, to);
    vectors++; if (to || cyc + 1 != 5) begin miscompares++; $display("[TB] FAIL b2b_spacing got %0d want 5 (timeout=%0b)", cyc + 1, to); end
    vectors++; if ({sum0, cout0, ov0} !== {es2, ec2, eo2}) begin miscompares++; $display("[TB] FAIL b2b_second got %h/%b/%b want %h/%b/%b", sum0, cout0, ov0, es2, ec2, eo2); end
    last0 = es2;
    tick();
  endtask

  task automatic test_random;
    logic [15:0] xa, xb, es;
    logic        xc, ec, eo;
    int          cyc;
    bit          to;
    for (int i = 0; i < 20; i++) begin
      xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom);
      if (i % 5 == 0) xb = ~xa;
      model(xa, xb, xc, es, ec, eo);
      start_op(xa, xb, xc, 1'b0);
      a = 16'($urandom);
      b = 16'($urandom);
      wait_done(1'b0, cyc, to);
      vectors++; if (to || cyc != 4) begin miscompares++; $display("[TB] FAIL rnd_latency[%0d] got %0d want 4 (timeout=%0b)", i, cyc, to); end
      vectors++; if ({sum0, cout0, ov0} !== {es, ec, eo}) begin miscompares++; $display("[TB] FAIL rnd_result[%0d] %h+%h+%b got %h/%b/%b want %h/%b/%b", i, xa, xb, xc, sum0, cout0, ov0, es, ec, eo); end
      last0 = es;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_n1;
    logic [15:0] xa, xb, es;
    logic        xc, ec, eo;
    int          cyc;
    bit          to;
    for (int i = 0; i < 9; i++) begin
      xa = (i == 0) ? 16'hFFFF : 16'($urandom);
      xb = (i == 0) ? 16'hFFFF : 16'($urandom);
      xc = (i == 0) ? 1'b1 : 1'($urandom);
      model(xa, xb, xc, es, ec, eo);
      start_op(xa, xb, xc, 1'b1);
      wait_done(1'b1, cyc, to);
      vectors++; if (to || cyc != 1) begin miscompares++; $display("[TB] FAIL n1_latency[%0d] got %0d want 1 (timeout=%0b)", i, cyc, to); end
      vectors++; if ({sum1, cout1, ov1} !== {es, ec, eo}) begin miscompares++; $display("[TB] FAIL n1_result[%0d] got %h/%b/%b want %h/%b/%b", i, sum1, cout1, ov1, es, ec, eo); end
      last1 = es;
      tick();
      vectors++; if (done1 !== 1'b0) begin miscompares++; $display("[TB] FAIL n1_done_pulse[%0d] got %b want 0", i, done1); end
    end
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_ctrl got busy=%b done=%b want 0 0", busy0, done0); end
    vectors++; if ({sum0, cout0, ov0} !== 18'h0) begin miscompares++; $display("[TB] FAIL midrst_outputs got %h/%b/%b want 0000/0/0", sum0, cout0, ov0); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done0 === 1'b1 || busy0 === 1'b1) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_no_done got activity=%b want 0", seen); end
    last0 = '0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_reject();
    test_back_to_back();
    test_random();
    test_n1();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
